// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment digit scanner.
//   state_t    : scan FSM state (GUARD = all digits off, DRIVE = one digit on)
//   SEG_BLANK  : decoder input code that produces a blank digit
//   cnt_width  : width of a counter that must reach max(a,b)-1
package seg_scan_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [3:0] SEG_BLANK = 4'hF;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-data update handshake between the timer/FSM (master) and the
// scanner (slave).
//   req  : master -> slave, level request; held until ack is seen
//   data : master -> slave, 4 bits per digit, [3:0] = digit 0 (rightmost)
//   ack  : slave -> master, one-cycle pulse the cycle after data is captured
// Handshake: the master raises req with data and keeps both stable until
// ack. The slave captures only at a frame boundary, so a transfer happens
// when req is high in the frame_tick cycle; ack follows one cycle later.
// Dropping req before a boundary cancels the request (no capture, no ack).
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    req;
    logic [4*NUM_DIGITS-1:0] data;
    logic                    ack;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/seg_scan_timer.sv
// Terminal counter for the scanner dwell/guard phases.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0, suppresses tc
//   term       : terminal value; counts 0..term then wraps to 0
//   tc         : high while cnt == term (the last cycle of the phase)
//   cnt        : current count
module seg_scan_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic         tc,
    output logic [W-1:0] cnt
);

    assign tc = !clr && (cnt == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes NUM_DIGITS 4-bit digits onto one shared 7-segment
// decoder, with an all-off guard period before every digit and a
// frame-synchronous double buffer for display data.
//   clk, rst_n  : clock, async active-low reset
//   scan_en     : 1 = scan; 0 = all digits off, scan frozen on current digit
//   upd         : update handshake (slave side), see seg_scan_ctrl_if
//   seg_code    : digit value to the decoder, 4'hF = blank
//   dig_en_n    : one-hot-low digit enables, all ones = off
//   frame_tick  : one-cycle pulse as the scan wraps from the last digit
//   dbg_state   : current FSM state
// Build option: define LZ_BLANK_EN to blank leading zeros (digit 0 is
// always shown).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_CYC  = 50000,
    parameter int GUARD_CYC  = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    seg_scan_ctrl_if.slave        upd,
    output logic [3:0]            seg_code,
    output logic [NUM_DIGITS-1:0] dig_en_n,
    output logic                  frame_tick,
    output state_t                dbg_state
);

    localparam int CW = cnt_width(DWELL_CYC, GUARD_CYC);
    localparam int IW = $clog2(NUM_DIGITS);

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
    logic [CW-1:0]           term;
    logic [CW-1:0]           cnt;
    logic                    tc;
    logic                    ack_q, ack_nxt;
    logic                    tick_nxt;
    logic [3:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   den_nxt;

    assign term      = (state == DRIVE) ? CW'(DWELL_CYC - 1) : CW'(GUARD_CYC - 1);
    assign upd.ack   = ack_q;
    assign dbg_state = state;

    // Disabling the scan clears the counter, so re-enabling always starts
    // with a full guard period.
    seg_scan_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scan_en),
        .term  (term),
        .tc    (tc),
        .cnt   (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GUARD;
            idx        <= '0;
            shadow     <= {NUM_DIGITS{SEG_BLANK}};
            seg_code   <= SEG_BLANK;
            dig_en_n   <= '1;
            ack_q      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            seg_code   <= seg_nxt;
            dig_en_n   <= den_nxt;
            ack_q      <= ack_nxt;
            frame_tick <= tick_nxt;
        end
    end

    // Outputs are computed from the next-state values so the registered
    // outputs line up with the state register; seg_code therefore already
    // holds the new digit throughout its guard period.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        shadow_nxt = shadow;
        tick_nxt   = 1'b0;
        ack_nxt    = 1'b0;
        seg_nxt    = SEG_BLANK;
        den_nxt    = '1;

        if (!scan_en) begin
            state_nxt = GUARD;
        end else if (tc) begin
            if (state == GUARD) begin
                state_nxt = DRIVE;
            end else begin
                state_nxt = GUARD;
                if (idx == IW'(NUM_DIGITS - 1)) begin
                    idx_nxt  = '0;
                    tick_nxt = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
        end

        // Capture only in the frame_tick cycle so a frame is never torn.
        if (scan_en && frame_tick && upd.req) begin
            shadow_nxt = upd.data;
            ack_nxt    = 1'b1;
        end

        seg_nxt = shadow_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef LZ_BLANK_EN
        begin
            logic blank;
            // Blank when this digit and every higher digit are zero.
            blank = (idx_nxt != '0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((IW'(i) >= idx_nxt) && (shadow_nxt[4*i +: 4] != 4'h0)) begin
                    blank = 1'b0;
                end
            end
            if (blank) begin
                seg_nxt = SEG_BLANK;
            end
        end
`endif

        if (state_nxt == DRIVE) begin
            den_nxt[idx_nxt] = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
    import seg_scan_pkg::*;

    localparam int ND    = 4;
    localparam int DWELL = 8;
    localparam int GRD   = 2;
    localparam int FRAME = ND * (DWELL + GRD);   // 40 cycles
`ifdef LZ_BLANK_EN
    localparam logic [15:0] EXP_LZ = 16'hFF50;
`else
    localparam logic [15:0] EXP_LZ = 16'h0050;
`endif

    logic          clk;
    logic          rst_n;
    logic          scan_en;
    logic [3:0]    seg_code;
    logic [ND-1:0] dig_en_n;
    logic          frame_tick;
    state_t        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) upd_if ();

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .DWELL_CYC  (DWELL),
        .GUARD_CYC  (GRD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_en    (scan_en),
        .upd        (upd_if),
        .seg_code   (seg_code),
        .dig_en_n   (dig_en_n),
        .frame_tick (frame_tick),
        .dbg_state  (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        return v[d*4 +: 4];
    endfunction

    // k = cycles since the scan (re)started at guard of digit 0, cnt 0.
    // Each digit: 2 guard cycles then 8 drive cycles; frame = 40 cycles.
    task automatic check_cycle(input int k, input logic [15:0] disp, input bit ack_e);
        int         p;
        int         d;
        bit         drv;
        logic [3:0] e_den;
        p     = k % FRAME;
        d     = p / (DWELL + GRD);
        drv   = (p % (DWELL + GRD)) >= GRD;
        e_den = 4'hF;
        if (drv) e_den[d] = 1'b0;
        chk($sformatf("dig_en_n k=%0d", k), 16'(dig_en_n), 16'(e_den));
        chk($sformatf("seg_code k=%0d", k), 16'(seg_code), 16'(nib(disp, d)));
        chk($sformatf("frame_tick k=%0d", k), 16'(frame_tick), 16'((k > 0) && (p == 0)));
        chk($sformatf("upd_ack k=%0d", k), 16'(upd_if.ack), 16'(ack_e));
        chk($sformatf("state k=%0d", k), 16'(dbg_state), drv ? 16'(DRIVE) : 16'(GUARD));
    endtask

    initial begin
        rst_n       = 1'b0;
        scan_en     = 1'b0;
        upd_if.req  = 1'b0;
        upd_if.data = '0;

        // reset state
        tick(); tick(); tick();
        chk("rst dig_en_n", 16'(dig_en_n), 16'hF);
        chk("rst seg_code", 16'(seg_code), 16'hF);
        chk("rst upd_ack", 16'(upd_if.ack), 16'h0);
        chk("rst frame_tick", 16'(frame_tick), 16'h0);
        chk("rst state", 16'(dbg_state), 16'(GUARD));

        rst_n = 1'b1;
        tick(); tick();
        chk("idle dig_en_n", 16'(dig_en_n), 16'hF);

        // start scanning with an update pending from the first cycle
        scan_en     = 1'b1;
        upd_if.req  = 1'b1;
        upd_if.data = 16'h1234;
        for (int k = 1; k <= 135; k++) begin
            tick();
            check_cycle(k, (k <= FRAME) ? 16'hFFFF : 16'h1234, k == FRAME + 1);
            if (k == FRAME + 1) upd_if.req = 1'b0;
            // short request mid-frame, withdrawn before the boundary
            if (k == 85) begin
                upd_if.req  = 1'b1;
                upd_if.data = 16'h5678;
            end
            if (k == 88) upd_if.req = 1'b0;
            // k=135 is mid-drive of digit 1
            if (k == 135) scan_en = 1'b0;
        end

        // scan disabled: all off, frozen on digit 1
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("off dig_en_n %0d", i), 16'(dig_en_n), 16'hF);
            chk($sformatf("off frame_tick %0d", i), 16'(frame_tick), 16'h0);
            chk($sformatf("off seg_code %0d", i), 16'(seg_code), 16'h3);
            chk($sformatf("off state %0d", i), 16'(dbg_state), 16'(GUARD));
        end

        // re-enable: restarts at guard of digit 1 (k=10), then load 0050
        scan_en     = 1'b1;
        upd_if.req  = 1'b1;
        upd_if.data = 16'h0050;
        for (int k = 11; k <= 83; k++) begin
            tick();
            check_cycle(k, (k <= FRAME) ? 16'h1234 : EXP_LZ, k == FRAME + 1);
            if (k == FRAME + 1) upd_if.req = 1'b0;
        end

        // asynchronous reset mid-drive
        rst_n = 1'b0;
        #1;
        chk("arst dig_en_n", 16'(dig_en_n), 16'hF);
        chk("arst seg_code", 16'(seg_code), 16'hF);
        chk("arst state", 16'(dbg_state), 16'(GUARD));
        chk("arst frame_tick", 16'(frame_tick), 16'h0);
        chk("arst upd_ack", 16'(upd_if.ack), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
